// File: rtl/apb_csr_pkg.sv
// Shared types and constants for the APB-to-CSR bridge.
package apb_csr_pkg;

  localparam int          CSR_ADDR_W  = 5;
  localparam int          CSR_DATA_W  = 8;
  localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} bridge_state_e;

  // Transfer captured in the APB setup phase and held until completion.
  typedef struct packed {
    logic                  we;
    logic                  err;
    logic [CSR_ADDR_W-1:0] off;
    logic [CSR_DATA_W-1:0] wdata;
  } csr_req_t;

endpackage

// File: rtl/apb_csr_decode.sv
// Address window / alignment decode for the CSR bridge (purely combinational).
module apb_csr_decode
  import apb_csr_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int NUM_REGS  = 8
) (
  input  logic [ADDR_W-1:0]     paddr,
  output logic [CSR_ADDR_W-1:0] offset,
  output logic                  err
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WIN_B  = ADDR_W'(NUM_REGS * 4);

  logic [ADDR_W-1:0] off_full;

  // Underflow wraps off_full, so the below-base test must stand on its own.
  assign off_full = paddr - BASE_A;
  assign offset   = off_full[CSR_ADDR_W-1:0];
  assign err      = (paddr < BASE_A) | (off_full >= WIN_B) | (paddr[1:0] != 2'b00);

endmodule

// File: rtl/apb_csr_bridge.sv
// APB3 slave front-end driving the 8-entry CSR block's en/we/addr/wdata/rdata port.
module apb_csr_bridge
  import apb_csr_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int PDATA_W   = 32,
  parameter int BASE_ADDR = 0,
  parameter int NUM_REGS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [PDATA_W-1:0]    pwdata,
  output logic                  pready,
  output logic [PDATA_W-1:0]    prdata,
  output logic                  pslverr,
  output logic                  csr_en,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [CSR_DATA_W-1:0] csr_wdata,
  input  logic [CSR_DATA_W-1:0] csr_rdata,
  output logic [7:0]            err_cnt
);

  bridge_state_e         state_q, state_d;
  csr_req_t              req_q;
  logic [CSR_DATA_W-1:0] prdata_q;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [CSR_ADDR_W-1:0] dec_off;
  logic                  dec_err;
  logic                  setup;
  logic                  unused_pwdata;

  assign unused_pwdata = ^pwdata[PDATA_W-1:CSR_DATA_W];

  apb_csr_decode #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .paddr  (paddr),
    .offset (dec_off),
    .err    (dec_err)
  );

  assign setup = (state_q == IDLE) && psel && !penable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Dropping psel mid-transfer abandons it; a strobe already issued stands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup) state_d = ACCESS;
      ACCESS:  if (!psel) state_d = IDLE;
               else if (req_q.we || req_q.err) state_d = DONE;
               else state_d = RDWAIT;
      RDWAIT:  state_d = psel ? DONE : IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == DONE) && req_q.err && (err_cnt_q != ERR_CNT_MAX))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      prdata_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (setup) begin
        req_q.we    <= pwrite;
        req_q.err   <= dec_err;
        req_q.off   <= dec_off;
        req_q.wdata <= pwdata[CSR_DATA_W-1:0];
      end
      // CSR read data arrives one cycle after the strobe, i.e. in RDWAIT.
      if ((state_q == RDWAIT) && psel) prdata_q <= csr_rdata;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    csr_en    = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    if ((state_q == ACCESS) && !req_q.err) begin
      csr_en    = 1'b1;
      csr_we    = req_q.we;
      csr_addr  = req_q.off;
      csr_wdata = req_q.wdata;
    end
  end

  always_comb begin
    pready  = (state_q == DONE);
    pslverr = (state_q == DONE) && req_q.err;
    prdata  = '0;
    if ((state_q == DONE) && !req_q.we && !req_q.err)
      prdata[CSR_DATA_W-1:0] = prdata_q;
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_csr_bridge.sv
// Directed bench for apb_csr_bridge with a small registered-read CSR block model.
module tb_apb_csr_bridge;

  localparam int          ADDR_W  = 12;
  localparam int          PDATA_W = 32;
  localparam logic [11:0] BASE    = 12'h100;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [ADDR_W-1:0]  paddr = '0;
  logic [PDATA_W-1:0] pwdata = '0;
  logic               pready, pslverr, csr_en, csr_we;
  logic [PDATA_W-1:0] prdata;
  logic [4:0]         csr_addr;
  logic [7:0]         csr_wdata, csr_rdata, err_cnt;

  int checks = 0;
  int errors = 0;

  apb_csr_bridge #(
    .ADDR_W(ADDR_W), .PDATA_W(PDATA_W), .BASE_ADDR(int'(BASE)), .NUM_REGS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .csr_en(csr_en), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // CSR block model: reset contents 0x30+i, read data registered.
  logic [7:0] mem [8];
  logic       unused_lsb;
  assign unused_lsb = ^csr_addr[1:0];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h30 + 8'(i);
      csr_rdata <= 8'h00;
    end else if (csr_en) begin
      if (csr_we) mem[csr_addr[4:2]] <= csr_wdata;
      else        csr_rdata <= mem[csr_addr[4:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One APB transfer starting with setup now (just after a rising edge).
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                      output int en_cnt, output int en_lat, output logic en_we,
                      output logic [4:0] en_addr, output logic [7:0] en_wdata,
                      output int rdy_lat, output logic [31:0] rdata, output logic slverr);
    en_cnt = 0; en_lat = 0; en_we = 1'b0; en_addr = '0; en_wdata = '0;
    rdy_lat = 0; rdata = 'x; slverr = 1'bx;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    for (int c = 1; c <= 6 && rdy_lat == 0; c++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      if (csr_en) begin
        en_cnt++; en_lat = c; en_we = csr_we; en_addr = csr_addr; en_wdata = csr_wdata;
      end
      if (pready) begin
        rdy_lat = c; rdata = prdata; slverr = pslverr;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  int         ec, el, rl;
  logic       ew, se;
  logic [4:0] ea;
  logic [7:0] ed;
  logic [31:0] rd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #3;
    chk("rst_pready", 32'(pready), 0);
    chk("rst_outs", {prdata[7:0], 7'd0, pslverr, 6'd0, csr_en, csr_we, 3'd0, csr_addr}, 0);
    chk("rst_wdata_cnt", {16'd0, csr_wdata, err_cnt}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Access phase with no setup is ignored
    psel = 1'b1; penable = 1'b1; paddr = BASE; pwrite = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("noset_ready_en", {pready, csr_en}, 0);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    // Write BASE+0x08 = A5
    xfer(1'b1, BASE + 12'h008, 32'hFFFF_FFA5, ec, el, ew, ea, ed, rl, rd, se);
    chk("wr08_en", {ec[7:0], el[7:0], 7'd0, ew}, {8'd1, 8'd1, 8'd1});
    chk("wr08_addr_data", {ea, ed}, {5'h08, 8'hA5});
    chk("wr08_ready", {rl[7:0], 7'd0, se}, {8'd2, 8'd0});
    chk("wr08_prdata", rd, 0);

    // Read back BASE+0x08
    xfer(1'b0, BASE + 12'h008, 0, ec, el, ew, ea, ed, rl, rd, se);
    chk("rd08_en", {ec[7:0], el[7:0], 7'd0, ew}, {8'd1, 8'd1, 8'd0});
    chk("rd08_addr", 32'(ea), 32'h08);
    chk("rd08_ready", {rl[7:0], 7'd0, se}, {8'd3, 8'd0});
    chk("rd08_prdata", rd, 32'h0000_00A5);

    // Out-of-window and misaligned writes
    xfer(1'b1, BASE + 12'h020, 32'h11, ec, el, ew, ea, ed, rl, rd, se);
    chk("wr20_err", {ec[7:0], rl[7:0], 7'd0, se}, {8'd0, 8'd2, 8'd1});
    xfer(1'b1, BASE + 12'h005, 32'h22, ec, el, ew, ea, ed, rl, rd, se);
    chk("wr05_err", {ec[7:0], rl[7:0], 7'd0, se}, {8'd0, 8'd2, 8'd1});
    chk("errcnt_2", 32'(err_cnt), 2);

    // Below-base read, last valid register
    xfer(1'b0, BASE - 12'h004, 0, ec, el, ew, ea, ed, rl, rd, se);
    chk("rd_below_err", {ec[7:0], rl[7:0], 7'd0, se}, {8'd0, 8'd2, 8'd1});
    chk("rd_below_prdata", rd, 0);
    chk("errcnt_3", 32'(err_cnt), 3);
    xfer(1'b0, BASE + 12'h01C, 0, ec, el, ew, ea, ed, rl, rd, se);
    chk("rd1c_reset", rd, 32'h37);
    xfer(1'b1, BASE + 12'h01C, 32'h5A, ec, el, ew, ea, ed, rl, rd, se);
    chk("wr1c", {ea, ed, 7'd0, se}, {5'h1C, 8'h5A, 8'd0});
    xfer(1'b0, BASE + 12'h01C, 0, ec, el, ew, ea, ed, rl, rd, se);
    chk("rd1c", {rd[23:0], rl[7:0]}, {24'h5A, 8'd3});

    // Errored write aborted in ACCESS: no pready, no err_cnt bump
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 12'h024;
    @(posedge clk); #1;
    chk("abort_err_en", 32'(csr_en), 0);
    psel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_err_ready", 32'(pready), 0);
    end
    chk("abort_err_cnt", 32'(err_cnt), 3);

    // 260 errored reads saturate err_cnt
    for (int i = 0; i < 260; i++) begin
      xfer(1'b0, BASE + 12'h040, 0, ec, el, ew, ea, ed, rl, rd, se);
      chk("sat_rd", {rd[15:0], ec[3:0], rl[3:0], 7'd0, se}, {16'd0, 4'd0, 4'd2, 8'd1});
    end
    chk("errcnt_sat", 32'(err_cnt), 255);

    // Read with psel dropped in RDWAIT
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = BASE + 12'h004;
    @(posedge clk); #1;
    chk("abort_rd_en", 32'(csr_en), 1);
    penable = 1'b1;
    @(posedge clk); #1;
    chk("abort_rd_rdwait", {pready, csr_en}, 0);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_rd_ready", 32'(pready), 0);
    end
    xfer(1'b1, BASE + 12'h00C, 32'h3C, ec, el, ew, ea, ed, rl, rd, se);
    chk("post_abort_wr", {ec[7:0], rl[7:0], 7'd0, se, ea, ed}, {8'd1, 8'd2, 8'd0, 5'h0C, 8'h3C});
    xfer(1'b0, BASE + 12'h00C, 0, ec, el, ew, ea, ed, rl, rd, se);
    chk("post_abort_rd", rd, 32'h3C);

    // Reset during ACCESS of a write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 12'h010; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("rstmid_en_before", 32'(csr_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_outs", {pready, pslverr, csr_en, csr_we, csr_addr, csr_wdata, err_cnt}, 0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, BASE + 12'h000, 0, ec, el, ew, ea, ed, rl, rd, se);
    chk("rstmid_rd00", {rd[23:0], rl[7:0]}, {24'h30, 8'd3});
    xfer(1'b0, BASE + 12'h010, 0, ec, el, ew, ea, ed, rl, rd, se);
    chk("rstmid_rd10", rd, 32'h34);
    xfer(1'b0, BASE + 12'h008, 0, ec, el, ew, ea, ed, rl, rd, se);
    chk("rstmid_rd08", rd, 32'h32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_csr_bridge.md
Name: apb_csr_bridge

Overview:
APB3 slave front-end that drives the 8-entry CSR block's simple en/we/addr/wdata/rdata port. It converts APB setup and access phases into a single-cycle CSR strobe. It inserts wait states to cover the CSR block's 1-cycle registered read latency. It decodes the address window and flags bad accesses with PSLVERR. It sits between the system APB interconnect and the CSR block.

Parameters:
ADDR_W, 12, APB address width
PDATA_W, 32, APB data width (>= 8)
BASE_ADDR, 0, byte base of CSR window (4-byte aligned)
NUM_REGS, 8, CSR count; window = NUM_REGS*4 bytes (max 8, since csr_addr[4:2] indexes)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  APB write
paddr  in  ADDR_W  APB byte address
pwdata  in  PDATA_W  APB write data (only [7:0] used)
pready  out  1  APB ready
prdata  out  PDATA_W  APB read data, zero-extended from 8 bits
pslverr  out  1  APB error, valid only with pready
csr_en  out  1  CSR access strobe
csr_we  out  1  CSR write
csr_addr  out  5  CSR byte offset (word index in [4:2], [1:0]=0)
csr_wdata  out  8  CSR write data
csr_rdata  in  8  CSR read data, registered, valid the cycle after the read strobe
err_cnt  out  8  saturating count of PSLVERR responses

Behaviour:
- FSM states: IDLE, ACCESS, RDWAIT, DONE. Reset → IDLE.
- All outputs are registered or decoded from state; no combinational path from APB inputs to outputs.
- Reset values: pready=0, prdata=0, pslverr=0, csr_en=0, csr_we=0, csr_addr=0, csr_wdata=0, err_cnt=0, internal capture regs=0.
- IDLE, psel&!penable (setup):
  - capture pwrite, pwdata[7:0], offset = paddr - BASE_ADDR.
  - err_q = (paddr < BASE_ADDR) | (offset >= NUM_REGS*4) | (paddr[1:0] != 0).
  - go to ACCESS.
- IDLE, psel&penable with no prior setup: protocol violation; ignore, stay IDLE, pready stays 0.
- ACCESS:
  - if !err_q: csr_en=1, csr_we=pwrite_q, csr_addr=offset[4:0], csr_wdata=wdata_q, held for exactly this one cycle.
  - next state: write or err_q → DONE; read → RDWAIT.
- RDWAIT: csr_en=0; capture csr_rdata into prdata_q; go to DONE.
- DONE:
  - pready=1, pslverr=err_q, prdata={0,prdata_q} on reads.
  - prdata=0 on writes and errored reads.
  - next state: IDLE.
- Latency from setup cycle T0: ACCESS at T1, pready at T2 for writes and errors, T3 for reads.
- Errored accesses never assert csr_en, so no write side effect and no read of the CSR block.
- err_cnt increments by 1 in DONE when err_q=1 and saturates at 255.
- psel deasserted in ACCESS or RDWAIT (APB violation): abort to IDLE, no pready, no err_cnt update. A write strobe already issued is not undone.
- Back-to-back: a new setup may arrive the cycle after DONE; IDLE accepts it immediately, so there are no idle gaps beyond the APB protocol.
- Reset mid-transfer: async return to IDLE with all outputs at reset values; the pending APB transfer is dropped.

Decomposition:
- Package apb_csr_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} bridge_state_e
  - localparams CSR_ADDR_W=5, CSR_DATA_W=8, ERR_CNT_MAX=8'hFF
- One sub-module, apb_csr_decode: combinational; takes paddr and produces offset[4:0] and err. Keeps window/alignment checks separately testable.

Test Plan:
- Write paddr=BASE+0x08, pwdata=0xA5 → csr_en=1 & csr_we=1 & csr_addr=0x08 & csr_wdata=0xA5 for one cycle at T1; pready=1, pslverr=0 at T2.
- Read paddr=BASE+0x08 after that write → csr_en=1 & csr_we=0 at T1; pready=1, prdata=0x000000A5, pslverr=0 at T3.
- Write paddr=BASE+0x20, then paddr=BASE+0x05 → csr_en never asserted; pready=1, pslverr=1 at T2 each time; err_cnt=2.
- 260 errored reads → err_cnt saturates at 255, prdata=0 each time.
- Read with psel dropped during RDWAIT → FSM returns to IDLE, no pready; the next valid write completes normally.
- rst_n asserted during ACCESS of a write → csr_en=0 and pready=0 immediately; after release, a read of BASE+0x00 returns the CSR block's reset contents.
